// File: rtl/valid_ready_pkg.sv
// Shared types and helpers for the valid/ready round-robin arbiter.
package valid_ready_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;

  // Packet-lock FSM states (only used when the lock feature is built in)
  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_e;

  // Round-robin successor: (idx + 1) mod n
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// pointer sits at position 0, take the lowest set bit, then map the
// rotated position back to a requester index.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   pointer_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned pos;

  // Search pointer, pointer+1, ... (mod NUM_REQ); first requester found wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(pointer_i) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!any_o && req_i[pos]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(pos);
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/valid_ready_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage among
// NUM_REQ valid/ready requesters. One-cycle latency, one beat per cycle.
// Optional packet lock (hold the grant until down_last) is built in when
// the macro VALID_READY_RR_ARBITER_LOCK_EN is defined.
module valid_ready_rr_arbiter
  import valid_ready_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        down_valid,
  input  logic [NUM_REQ*DATA_W-1:0] down_data,
  input  logic [NUM_REQ-1:0]        down_last,
  output logic [NUM_REQ-1:0]        down_ready,
  input  logic                      up_ready,
  output logic                      up_valid,
  output logic [DATA_W-1:0]         up_data,
  output logic [IDX_W-1:0]          up_src,
  output logic                      up_last
);

  logic                 up_valid_q, up_valid_d;
  logic [DATA_W-1:0]    up_data_q, up_data_d;
  logic [IDX_W-1:0]     up_src_q, up_src_d;
  logic                 up_last_q, up_last_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 load;
  logic                 xfer;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [DATA_W-1:0]    win_data;
  logic                 win_last;
  logic [IDX_W-1:0]     ptr_next;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i    (down_valid),
    .pointer_i(ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

`ifdef VALID_READY_RR_ARBITER_LOCK_EN
  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;

  // While locked the grant stays on the packet owner even if it goes idle
  always_comb begin
    if (state_q == LOCKED) begin
      grant             = '0;
      grant[lock_idx_q] = 1'b1;
      win_idx           = lock_idx_q;
      win_valid         = down_valid[lock_idx_q];
    end else begin
      grant     = pick_grant;
      win_idx   = pick_idx;
      win_valid = pick_any;
    end
  end
`else
  assign grant     = pick_grant;
  assign win_idx   = pick_idx;
  assign win_valid = pick_any;
`endif

  assign load       = up_ready | ~up_valid_q;
  // Gating with reset_n keeps every requester stalled while reset is held
  assign down_ready = grant & {NUM_REQ{load & reset_n}};
  assign xfer       = win_valid & load & reset_n;
  assign ptr_next   = IDX_W'(rr_next(32'(win_idx), NUM_REQ));

  // Select the winner's payload and last flag
  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = down_data[i*DATA_W +: DATA_W];
        win_last = down_last[i];
      end
    end
  end

  // Next-state for the output stage, RR pointer and (optional) lock FSM
  always_comb begin
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_src_d   = up_src_q;
    up_last_d  = up_last_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      up_valid_d = 1'b1;
      up_data_d  = win_data;
      up_src_d   = win_idx;
      up_last_d  = win_last;
    end else if (load) begin
      up_valid_d = 1'b0;
    end
`ifdef VALID_READY_RR_ARBITER_LOCK_EN
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (win_last) begin
            ptr_d = ptr_next;
          end else begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end
        end
        LOCKED: begin
          if (win_last) begin
            state_d = IDLE;
            ptr_d   = ptr_next;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`else
    if (xfer) begin
      ptr_d = ptr_next;
    end
`endif
  end

  // State registers; reset discards any held beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_src_q   <= '0;
      up_last_q  <= 1'b0;
      ptr_q      <= '0;
`ifdef VALID_READY_RR_ARBITER_LOCK_EN
      state_q    <= IDLE;
      lock_idx_q <= '0;
`endif
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_src_q   <= up_src_d;
      up_last_q  <= up_last_d;
      ptr_q      <= ptr_d;
`ifdef VALID_READY_RR_ARBITER_LOCK_EN
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign up_valid = up_valid_q;
  assign up_data  = up_data_q;
  assign up_src   = up_src_q;
  assign up_last  = up_last_q;

endmodule

// File: tb/tb_valid_ready_rr_arbiter.sv
// Directed bench for valid_ready_rr_arbiter (NUM_REQ=4, DATA_W=8).
module tb_valid_ready_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   down_valid;
  logic [N*W-1:0] down_data;
  logic [N-1:0]   down_last;
  logic [N-1:0]   down_ready;
  logic           up_ready;
  logic           up_valid;
  logic [W-1:0]   up_data;
  logic [1:0]     up_src;
  logic           up_last;

  int vectors;
  int miscompares;

  valid_ready_rr_arbiter #(
    .NUM_REQ(N),
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .down_valid(down_valid),
    .down_data (down_data),
    .down_last (down_last),
    .down_ready(down_ready),
    .up_ready  (up_ready),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_src    (up_src),
    .up_last   (up_last)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    down_valid = '0;
    down_last  = '0;
    up_ready   = 1'b1;
    down_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    down_valid = 4'hF;
    down_last  = '0;
    up_ready   = 1'b1;
    down_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    tick();
    vectors++;
    if (up_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_up_valid: got %b expected 0", up_valid);
    end
    vectors++;
    if (down_ready !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_down_ready: got %b expected 0000", down_ready);
    end
    vectors++;
    if (up_data !== 8'h00 || up_src !== 2'd0 || up_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h src=%0d last=%b expected 00/0/0",
               up_data, up_src, up_last);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd0 || up_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL reset_first_beat: got valid=%b src=%0d data=%h expected 1/0/a0",
               up_valid, up_src, up_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src;
    do_reset();
    down_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_src = 2'(i % 4);
      vectors++;
      if (up_valid !== 1'b1 || up_src !== exp_src || up_data !== (8'hA0 + 8'(exp_src))) begin
        miscompares++;
        $display("FAIL rr_beat%0d: got valid=%b src=%0d data=%h expected 1/%0d/%h",
                 i, up_valid, up_src, up_data, exp_src, 8'hA0 + 8'(exp_src));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    down_valid = 4'hF;
    tick();
    up_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (down_ready !== 4'h0) begin
        miscompares++;
        $display("FAIL bp_ready%0d: got %b expected 0000", i, down_ready);
      end
      vectors++;
      if (up_valid !== 1'b1 || up_src !== 2'd0 || up_data !== 8'hA0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b src=%0d data=%h expected 1/0/a0",
                 i, up_valid, up_src, up_data);
      end
      tick();
    end
    up_ready = 1'b1;
    #1;
    vectors++;
    if (down_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b expected 0010", down_ready);
    end
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd1 || up_data !== 8'hA1) begin
      miscompares++;
      $display("FAIL bp_next: got valid=%b src=%0d data=%h expected 1/1/a1",
               up_valid, up_src, up_data);
    end
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_no_bubble: got valid=%b src=%0d expected 1/2", up_valid, up_src);
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    down_valid = 4'b1000;
    #1;
    vectors++;
    if (down_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL sparse_ready3: got %b expected 1000", down_ready);
    end
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd3 || up_data !== 8'hA3) begin
      miscompares++;
      $display("FAIL sparse_src3: got valid=%b src=%0d data=%h expected 1/3/a3",
               up_valid, up_src, up_data);
    end
    // Pointer wrapped to 0: requester 0 beats requester 1
    down_valid = 4'b0011;
    #1;
    vectors++;
    if (down_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_ptr0: got %b expected 0001", down_ready);
    end
    down_valid = 4'b0010;
    #1;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd1 || up_data !== 8'hA1) begin
      miscompares++;
      $display("FAIL sparse_src1: got valid=%b src=%0d data=%h expected 1/1/a1",
               up_valid, up_src, up_data);
    end
    // Pointer is now 2: among {0,1,3} requester 3 is next
    down_valid = 4'b1011;
    #1;
    vectors++;
    if (down_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL ptr2_pick: got %b expected 1000", down_ready);
    end
    down_valid = 4'b0000;
    tick();
    vectors++;
    if (up_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_valid: got %b expected 0", up_valid);
    end
    down_valid = 4'b1011;
    #1;
    vectors++;
    if (down_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL ptr_hold_idle: got %b expected 1000", down_ready);
    end
  endtask

`ifdef VALID_READY_RR_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    down_valid            = 4'b0100;
    down_last             = 4'b0000;
    down_data[2*W +: W]   = 8'hC0;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd2 || up_data !== 8'hC0 || up_last !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_beat0: got valid=%b src=%0d data=%h last=%b expected 1/2/c0/0",
               up_valid, up_src, up_data, up_last);
    end
    down_valid          = 4'b0101;
    down_data[2*W +: W] = 8'hC1;
    #1;
    vectors++;
    if (down_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL lock_ready: got %b expected 0100", down_ready);
    end
    tick();
    vectors++;
    if (up_src !== 2'd2 || up_data !== 8'hC1) begin
      miscompares++;
      $display("FAIL lock_beat1: got src=%0d data=%h expected 2/c1", up_src, up_data);
    end
    // Owner goes idle mid-packet: requester 0 must stay stalled
    down_valid = 4'b0001;
    #1;
    vectors++;
    if (down_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL lock_stall: got %b expected 0100", down_ready);
    end
    tick();
    vectors++;
    if (up_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_gap: got valid=%b expected 0", up_valid);
    end
    down_valid          = 4'b0101;
    down_last           = 4'b0100;
    down_data[2*W +: W] = 8'hC2;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd2 || up_data !== 8'hC2 || up_last !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_last: got valid=%b src=%0d data=%h last=%b expected 1/2/c2/1",
               up_valid, up_src, up_data, up_last);
    end
    down_valid = 4'b0001;
    down_last  = 4'b0000;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd0 || up_data !== 8'hA0) begin
      miscompares++;
      $display("FAIL lock_release: got valid=%b src=%0d data=%h expected 1/0/a0",
               up_valid, up_src, up_data);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    down_valid = 4'b0100;
    down_last  = 4'b0000;
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd2) begin
      miscompares++;
      $display("FAIL ar_setup: got valid=%b src=%0d expected 1/2", up_valid, up_src);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (up_valid !== 1'b0 || up_src !== 2'd0 || up_data !== 8'h00) begin
      miscompares++;
      $display("FAIL ar_clear: got valid=%b src=%0d data=%h expected 0/0/00",
               up_valid, up_src, up_data);
    end
    tick();
    reset_n    = 1'b1;
    down_valid = 4'b1010;
    down_last  = 4'hF;
    #1;
    // Cleared pointer (0) picks 1; a stale pointer or lock would not
    vectors++;
    if (down_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL ar_ptr_clear: got %b expected 0010", down_ready);
    end
    tick();
    vectors++;
    if (up_valid !== 1'b1 || up_src !== 2'd1 || up_last !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_after: got valid=%b src=%0d last=%b expected 1/1/1",
               up_valid, up_src, up_last);
    end
  endtask

  initial begin
    clk         = 1'b0;
    reset_n     = 1'b0;
    down_valid  = '0;
    down_data   = '0;
    down_last   = '0;
    up_ready    = 1'b0;
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
`ifdef VALID_READY_RR_ARBITER_LOCK_EN
    test_lock();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/valid_ready_rr_arbiter.md
Name: valid_ready_rr_arbiter

Overview:
- Shares one registered valid/ready output channel among NUM_REQ valid/ready requesters using round-robin arbitration.
- Output is a single-entry register stage with one-cycle latency and full throughput.
- Sits upstream of the existing valid/ready slice chain. Replaces ad-hoc ORing of producers onto one channel.

Parameters:
- NUM_REQ, 4, number of requester channels (2..16)
- DATA_W, 8, payload width per channel
- IDX_W, $clog2(NUM_REQ), width of requester index (derived, not overridden)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- down_valid  in  NUM_REQ  per-requester valid
- down_data  in  NUM_REQ*DATA_W  per-requester payload, requester i at bits [i*DATA_W +: DATA_W]
- down_last  in  NUM_REQ  per-requester end-of-packet; used only when the lock feature is enabled
- down_ready  out  NUM_REQ  per-requester ready
- up_ready  in  1  downstream ready
- up_valid  out  1  registered output valid
- up_data  out  DATA_W  registered output payload
- up_src  out  IDX_W  registered index of the requester that produced up_data
- up_last  out  1  registered copy of the winner's down_last

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - up_valid=0, up_data=0, up_src=0, up_last=0.
  - RR pointer=0. State=IDLE.
- Stage enable: load = up_ready | ~up_valid.
- Grant (combinational, one-hot or zero):
  - Winner is the first requester with down_valid set, searching pointer, pointer+1, ... modulo NUM_REQ.
  - grant is all-zero when no down_valid is set.
- down_ready[i] = grant[i] & load.
- Non-granted requesters always see ready=0, even when the stage is empty.
- Transfer on requester i occurs when down_valid[i] & down_ready[i].
- On transfer, next cycle:
  - up_valid=1
  - up_data=down_data[i]
  - up_src=i
  - up_last=down_last[i]
- Output consumed (up_valid & up_ready) with no new transfer in the same cycle: up_valid goes to 0.
- Consume and transfer in the same cycle: the new beat replaces the old with no bubble, sustaining 1 beat/cycle.
- When load=0, up_data, up_src and up_last are held stable.
- RR pointer updates only on a transfer: pointer = (i+1) mod NUM_REQ.
  - Wrap: a winner of NUM_REQ-1 sets pointer=0.
  - No transfer leaves the pointer unchanged.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 transfers.
- A requester dropping valid before a transfer is legal. Arbitration re-evaluates every cycle; the grant is not sticky without the lock feature.
- Single requester active: it gets every beat.
- Reset asserted mid-stream: any held output beat is discarded. The upstream protocol is responsible for replay.

Optional Feature:
- Macro: VALID_READY_RR_ARBITER_LOCK_EN
- When defined:
  - Two-state FSM, IDLE and LOCKED.
  - IDLE -> LOCKED on a transfer with down_last=0; the winner index is stored as lock_idx.
  - In LOCKED, grant is forced to lock_idx whether or not that requester is valid. Other requesters stall.
  - LOCKED -> IDLE on a transfer from lock_idx with down_last=1.
  - The RR pointer updates only on the transfer that returns the FSM to IDLE. A transfer with last=1 taken in IDLE stays in IDLE and updates the pointer.
  - Reset returns the FSM to IDLE.
- When undefined:
  - No FSM. down_last is only passed through to up_last.
  - Arbitration happens every beat.

Decomposition:
- Package valid_ready_pkg holds:
  - NUM_REQ_DEF=4 and DATA_W_DEF=8
  - arb_state_e enum {IDLE, LOCKED}
  - function rr_next(idx, n), returning (idx+1) mod n
- Sub-module rr_pick (parameters NUM_REQ):
  - Pure combinational rotate, priority-encode, unrotate.
  - Inputs: req, pointer. Outputs: one-hot grant, winner index, any.
  - Instantiated once.

Test Plan:
1. Reset: hold reset_n=0 while driving down_valid=4'hF -> up_valid=0 and down_ready=0. After release with up_ready=1, the first up_src=0.
2. Round-robin: all 4 valid, up_ready=1, 8 cycles -> up_src sequence 0,1,2,3,0,1,2,3 at 1 beat/cycle, each up_data matching the source's down_data.
3. Backpressure: up_ready=0 for 3 cycles with a beat held -> up_data, up_src and down_ready=0 all stable. On up_ready=1 the next winner follows with no bubble.
4. Sparse and wrap: only requester 3 valid, then only requester 1 -> up_src 3 then 1. Pointer wraps to 0 after 3, then becomes 2 after 1.
5. Lock (macro defined): requester 2 sends 3 beats with last on the 3rd, requester 0 valid throughout -> up_src 2,2,2,0. Requester 2 dropping valid mid-packet stalls requester 0 (down_ready[0]=0).
6. Async reset mid-stream: reset_n asserted with up_valid=1 -> up_valid=0 immediately, and the FSM and pointer are cleared.
